// File: rtl/bitin_debounce.sv
// rtl/bitin_debounce.sv - Avalon-MM input-bit peripheral: sync, debounce, edge capture, maskable irq
// Pin is synchronised, debounced (or bypassed), edge-detected into a sticky W1C capture bit.
module bitin_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic [1:0]  avs_s1_address,
  input  logic        avs_s1_read,
  output logic [31:0] avs_s1_readdata,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic        ins_irq,
  input  logic        coe_bit
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   db_q, db_d;
  logic                   db_prev_q, db_prev_d;
  logic                   edge_cap_q, edge_cap_d;
  logic                   irq_mask_q, irq_mask_d;
  logic [1:0]             edge_sel_q, edge_sel_d;
  logic                   bypass_q, bypass_d;

  logic sync;
  logic rise, fall, hit, clr;
  logic unused_ok;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign unused_ok = ^{avs_s1_read, avs_s1_writedata[31:3]};

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], coe_bit};

    // count only runs while the synchronised level disagrees with db
    db_d    = db_q;
    count_d = '0;
    if (bypass_q) begin
      db_d = sync;
    end else if (sync != db_q) begin
      if (count_q == CNT_MAX) begin
        db_d = sync;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end

    db_prev_d = db_q;
    rise      = db_q & ~db_prev_q;
    fall      = ~db_q & db_prev_q;
    hit       = ((edge_sel_q == 2'b00) & rise) |
                ((edge_sel_q == 2'b01) & fall) |
                ((edge_sel_q == 2'b10) & (rise | fall));

    // set beats a coincident W1C clear
    clr        = avs_s1_write & (avs_s1_address == 2'd2) & avs_s1_writedata[0];
    edge_cap_d = hit | (edge_cap_q & ~clr);

    irq_mask_d = irq_mask_q;
    edge_sel_d = edge_sel_q;
    bypass_d   = bypass_q;
    if (avs_s1_write && avs_s1_address == 2'd1) begin
      irq_mask_d = avs_s1_writedata[0];
    end
    if (avs_s1_write && avs_s1_address == 2'd3) begin
      edge_sel_d = avs_s1_writedata[1:0];
      bypass_d   = avs_s1_writedata[2];
    end
  end

  always_comb begin
    avs_s1_readdata = '0;
    case (avs_s1_address)
      2'd0:    avs_s1_readdata[0]   = db_q;
      2'd1:    avs_s1_readdata[0]   = irq_mask_q;
      2'd2:    avs_s1_readdata[0]   = edge_cap_q;
      default: avs_s1_readdata[2:0] = {bypass_q, edge_sel_q};
    endcase
  end

  assign ins_irq = edge_cap_q & irq_mask_q;

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      sync_q     <= '0;
      count_q    <= '0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      edge_cap_q <= 1'b0;
      irq_mask_q <= 1'b0;
      edge_sel_q <= 2'b00;
      bypass_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      count_q    <= count_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      edge_sel_q <= edge_sel_d;
      bypass_q   <= bypass_d;
    end
  end

endmodule
